imm_encoder: RTL

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder_pkg.sv | 29 ++
 rtl/imm_pack.sv | 50 +++++
 rtl/imm_encoder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/imm_encoder_pkg.sv
// Shared encodings for the immediate encoder: format codes, RV32I opcodes,
// FSM states and small instruction-builder helpers.
package imm_encoder_pkg;

  localparam logic [2:0] EXT_I      = 3'b000;
  localparam logic [2:0] EXT_S      = 3'b001;
  localparam logic [2:0] EXT_B      = 3'b010;
  localparam logic [2:0] EXT_U      = 3'b011;
  localparam logic [2:0] EXT_J      = 3'b100;
  localparam logic [2:0] EXT_LI_DEF = 3'b101;

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    EMIT2
  } state_e;

  function automatic logic [31:0] mk_addi(logic [4:0] rd, logic [4:0] rs1, logic [11:0] lo);
    return {lo, rs1, 3'b000, rd, OP_IMM};
  endfunction

  function automatic logic [31:0] mk_lui(logic [4:0] rd, logic [19:0] hi);
    return {hi, rd, OP_LUI};
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational RV32I immediate insertion and encodability check; an
// unencodable immediate returns the template untouched with err set.
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] imm,
  input  logic [31:0] tmpl,
  output logic [31:0] inst,
  output logic        err
);

  logic fits12;
  logic fits13;
  logic fits21;
  logic [31:0] ins;

  always_comb begin
    fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
    fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
    fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);
    ins    = tmpl;
    err    = 1'b0;
    case (op)
      EXT_I: begin
        ins = {imm[11:0], tmpl[19:0]};
        err = !fits12;
      end
      EXT_S: begin
        ins = {imm[11:5], tmpl[24:12], imm[4:0], tmpl[6:0]};
        err = !fits12;
      end
      EXT_B: begin
        ins = {imm[12], imm[10:5], tmpl[24:12], imm[4:1], imm[11], tmpl[6:0]};
        err = !fits13 || imm[0];
      end
      EXT_U: begin
        ins = {imm[31:12], tmpl[11:0]};
        err = (imm[11:0] != '0);
      end
      EXT_J: begin
        ins = {imm[20], imm[10:1], imm[11], imm[19:12], tmpl[11:0]};
        err = !fits21 || imm[0];
      end
      default: err = 1'b1;
    endcase
    inst = err ? tmpl : ins;
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: one registered output word per request, or a LUI/ADDI
// pair for load-immediate, with valid/ready handshakes on both sides.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter logic [2:0] EXT_LI = EXT_LI_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_imm,
  input  logic [31:0] req_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic        out_last
);

  state_e      state_q;
  logic        ready_en_q;
  logic        out_valid_q;
  logic [31:0] out_inst_q;
  logic        out_err_q;
  logic        out_last_q;
  logic [31:0] second_q;

  logic        accept;
  logic        xfer;
  logic [31:0] pack_inst;
  logic        pack_err;
  logic [4:0]  li_rd;
  logic [19:0] li_hi;
  logic [11:0] li_lo;
  logic [31:0] first_d;
  logic [31:0] second_d;
  logic        err_d;
  logic        last_d;

  imm_pack u_pack (
    .op   (req_op),
    .imm  (req_imm),
    .tmpl (req_inst),
    .inst (pack_inst),
    .err  (pack_err)
  );

  assign req_ready = ready_en_q && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = req_valid && req_ready;
  assign xfer      = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;
  assign out_last  = out_last_q;

  always_comb begin
    li_rd    = req_inst[11:7];
    li_lo    = req_imm[11:0];
    // (imm + 0x800) >> 12: the +0x800 carries into bit 12 exactly when imm[11] is set
    li_hi    = req_imm[31:12] + {19'd0, req_imm[11]};
    second_d = mk_addi(li_rd, li_rd, li_lo);
    first_d  = pack_inst;
    err_d    = pack_err;
    last_d   = 1'b1;
    if (req_op == EXT_LI) begin
      err_d = 1'b0;
      if (li_hi == '0) begin
        first_d = mk_addi(li_rd, 5'd0, li_lo);
      end else if (li_lo == '0) begin
        first_d = mk_lui(li_rd, li_hi);
      end else begin
        first_d = mk_lui(li_rd, li_hi);
        last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_en_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
      second_q    <= '0;
    end else begin
      ready_en_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= EMIT;
            out_valid_q <= 1'b1;
            out_inst_q  <= first_d;
            out_err_q   <= err_d;
            out_last_q  <= last_d;
            second_q    <= second_d;
          end
        end
        EMIT: begin
          if (xfer) begin
            if (out_last_q) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
            end else begin
              state_q    <= EMIT2;
              out_inst_q <= second_q;
              out_last_q <= 1'b1;
            end
          end
        end
        EMIT2: begin
          if (xfer) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
